// File: rtl/mult_operand_sequencer.sv
// Byte-stream front/back end for an 8x8 signed multiplier stage.
// Takes the multiplicand and then the multiplier as bytes, and holds both on mul_a/mul_b.
// After a fixed settle time it captures the 16-bit product and emits it low byte first.
module mult_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  // A settle time of 0 is treated as 1, so the terminal count never underflows.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES <= 1) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    SETTLE,
    OUT_LO,
    OUT_HI
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        in_xfer;
  logic        out_xfer;

  assign in_ready  = (state_q == GET_A) || (state_q == GET_B);
  assign busy      = (state_q != GET_A);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;

  // Next-state and datapath decode; every register holds unless its own load condition fires.
  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      GET_A: begin
        if (in_xfer) begin
          mul_a_d = in_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (in_xfer) begin
          mul_b_d = in_data;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          prod_d      = mul_p;
          out_data_d  = mul_p[7:0];
          out_valid_d = 1'b1;
          state_d     = OUT_LO;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      OUT_LO: begin
        if (out_xfer) begin
          out_data_d = prod_q[15:8];
          state_d    = OUT_HI;
        end else begin
          out_data_d = prod_q[7:0];
        end
      end
      OUT_HI: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = GET_A;
        end
      end
      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // State and datapath registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
      cnt_q       <= 4'd0;
      prod_q      <= 16'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Testbench for mult_operand_sequencer.
// Two instances (settle time 2 and 1) share the stimulus; sel picks the active one.
// Expected bytes come from signed integer arithmetic, and expected timing from the handshake rules.
module tb_mult_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, busy;
  logic [7:0]  mul_a, mul_b, out_data;

  logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
  logic [7:0]  mul_a0, mul_b0, out_data0, mul_a1, mul_b1, out_data1;
  logic signed [15:0] mul_p0, mul_p1;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          prev_bp = 0;
  bit          contiguous = 1'b0;
  logic [7:0]  prev_b [2];

  // Free-running clock and a cycle counter used for the timing checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational signed multiplier models feeding each instance.
  assign mul_p0 = $signed(mul_a0) * $signed(mul_b0);
  assign mul_p1 = $signed(mul_a1) * $signed(mul_b1);

  // Route the observed outputs of the selected instance to the shared names.
  assign in_ready  = sel ? in_ready1  : in_ready0;
  assign out_valid = sel ? out_valid1 : out_valid0;
  assign busy      = sel ? busy1      : busy0;
  assign mul_a     = sel ? mul_a1     : mul_a0;
  assign mul_b     = sel ? mul_b1     : mul_b0;
  assign out_data  = sel ? out_data1  : out_data0;

  mult_operand_sequencer #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && !sel),
    .in_ready(in_ready0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready && !sel),
    .busy(busy0)
  );

  mult_operand_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid && sel),
    .in_ready(in_ready1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready && sel),
    .busy(busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s sel=%0d observed=%0h expected=%0h at t=%0t", tag, sel, observed, expected, $time);
    end
  endtask

  // One full transaction starting at a negedge in GET_A; bp = cycles of out_ready low after out_valid rises.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int bp);
    int ia, ib, s, waited, got;
    logic [15:0] p;
    ia = $signed(a);
    ib = $signed(b);
    p  = 16'(ia * ib);
    s  = sel ? 1 : 2;
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    in_data   = a;
    checkOutput("in_ready_get_a", in_ready, 1);
    checkOutput("busy_get_a", busy, 0);
    @(negedge clk);
    checkOutput("mul_a_load", mul_a, a);
    checkOutput("mul_b_hold_across", mul_b, prev_b[sel]);
    checkOutput("in_ready_get_b", in_ready, 1);
    checkOutput("busy_get_b", busy, 1);
    in_data = b;
    @(negedge clk);
    checkOutput("mul_b_load", mul_b, b);
    checkOutput("mul_a_hold", mul_a, a);
    waited = 0;
    while (!out_valid && waited < 20) begin
      checkOutput("in_ready_settle", in_ready, 0);
      checkOutput("out_valid_settle", out_valid, 0);
      in_data = 8'($urandom);
      @(negedge clk);
      waited++;
    end
    checkOutput("settle_latency", waited, s);
    if (contiguous) checkOutput("result_spacing", cyc - last_cyc, 4 + s + prev_bp);
    last_cyc   = cyc;
    prev_bp    = bp;
    contiguous = 1'b1;
    for (int i = 0; i < bp; i++) begin
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_data", out_data, p[7:0]);
      checkOutput("bp_in_ready", in_ready, 0);
      in_data = 8'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 6 && got < 2; i++) begin
      checkOutput("out_valid_hold", out_valid, 1);
      checkOutput("in_ready_out", in_ready, 0);
      checkOutput("mul_a_out", mul_a, a);
      checkOutput("mul_b_out", mul_b, b);
      if (out_valid) begin
        if (got == 0) checkOutput("out_lo_byte", out_data, p[7:0]);
        else          checkOutput("out_hi_byte", out_data, p[15:8]);
        got++;
      end
      in_data = 8'($urandom);
      @(negedge clk);
    end
    checkOutput("byte_count", got, 2);
    checkOutput("busy_after", busy, 0);
    checkOutput("in_ready_after", in_ready, 1);
    checkOutput("out_valid_after", out_valid, 0);
    prev_b[sel] = b;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Load operands, then pulse reset between clock edges while the selected instance is settling.
  task automatic resetMidSettle(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post_reset_no_output", out_valid, 0);
    end
    prev_b[0]  = 8'd0;
    prev_b[1]  = 8'd0;
    contiguous = 1'b0;
  endtask

  // Select the other instance while both are idle.
  task automatic switchInstance(input logic s);
    sel        = s;
    contiguous = 1'b0;
  endtask

  // Directed cases first, then a randomized run, then the summary.
  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prev_b[0] = 8'd0;
    prev_b[1] = 8'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_mul_a", mul_a, 0);
    checkOutput("reset_mul_b", mul_b, 0);
    checkOutput("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h03, 8'h05, 0);
    applyStimulus(8'hFD, 8'h04, 0);
    applyStimulus(8'h80, 8'h80, 0);
    applyStimulus(8'h7F, 8'h80, 0);
    applyStimulus(8'h03, 8'h05, 5);
    resetMidSettle(8'h55, 8'h66);
    applyStimulus(8'h07, 8'h06, 0);

    switchInstance(1'b1);
    applyStimulus(8'h03, 8'h05, 0);
    applyStimulus(8'hFD, 8'h04, 0);
    applyStimulus(8'h80, 8'h80, 0);
    resetMidSettle(8'h12, 8'h34);
    applyStimulus(8'h07, 8'h06, 2);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) switchInstance(~sel);
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
